game_ctrl: RTL and testbench

- Parametrised game sequencer for the snake design, sitting between the player inputs and the map `update` engine.
- Runs the game state machine, generates the movement tick with level-based speed-up, and handshakes each step with `update`.
- Keeps per-player BCD scores and the high score for `bin2display`.
- Successor to the single-player, fixed-rate timing: supports N players, pause, restart and difficulty levels.

---
 rtl/snake_pkg.sv | 18 +
 rtl/game_ctrl_if.sv | 29 ++
 rtl/bcd_counter.sv | 41 ++++
 rtl/game_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_game_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game sequencer: FSM encoding and field widths.
// Pure declarations, no timing; nothing here carries flow control.
package snake_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_PAUSE = 3'd4,
        S_OVER  = 3'd5
    } state_e;

    localparam int DIGIT_W = 4;
    localparam int LEVEL_W = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

endpackage

// File: rtl/game_ctrl_if.sv
// Player/update-engine side of game_ctrl; all controller outputs are registered.
// Pulse-based handshake: clear_req/step_req are answered by update_done.
interface game_ctrl_if #(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_DIGITS = 5
);
    logic                                  start;
    logic                                  pause_toggle;
    logic [NUM_PLAYERS-1:0]                fruit_eaten;
    logic [NUM_PLAYERS-1:0]                collision;
    logic                                  update_done;
    logic                                  clear_req;
    logic                                  step_req;
    logic [2:0]                            state;
    logic [NUM_PLAYERS-1:0]                alive;
    logic [3:0]                            level;
    logic [NUM_PLAYERS*4*SCORE_DIGITS-1:0] score;
    logic [4*SCORE_DIGITS-1:0]             high_score;

    modport master (
        output start, pause_toggle, fruit_eaten, collision, update_done,
        input  clear_req, step_req, state, alive, level, score, high_score
    );

    modport slave (
        input  start, pause_toggle, fruit_eaten, collision, update_done,
        output clear_req, step_req, state, alive, level, score, high_score
    );
endinterface

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD incrementer with synchronous clear.
// Count visible one cycle after inc_i; holds at all nines.
module bcd_counter
    import snake_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      inc_i,
    output logic [DIGITS*DIGIT_W-1:0] cnt_o
);
    logic [DIGITS*DIGIT_W-1:0] cnt_q, cnt_d;
    logic                      all9;

    always_comb begin
        logic carry;
        cnt_d = cnt_q;
        carry = 1'b1;
        all9  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q[i*DIGIT_W +: DIGIT_W] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (cnt_q[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
                    cnt_d[i*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    cnt_d[i*DIGIT_W +: DIGIT_W] = cnt_q[i*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) cnt_q <= '0;
        else if (inc_i && !all9) cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/game_ctrl.sv
// Snake game sequencer: FSM, level-scaled step tick, scores and high score.
// Outputs registered; each clear/step request waits on update_done.
module game_ctrl
    import snake_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int SCORE_DIGITS  = 5,
    parameter int TICK_DIV      = 5_000_000,
    parameter int DIV_STEP      = 500_000,
    parameter int MIN_DIV       = 1_000_000,
    parameter int SPEEDUP_EVERY = 5
) (
    input  logic      clk_i,
    input  logic      reset_i,
    game_ctrl_if.slave bus
);
    localparam int SW   = DIGIT_W*SCORE_DIGITS;
    localparam int FC_W = 8;

    state_e                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [NUM_PLAYERS-1:0] alive_q, alive_d;
    logic [LEVEL_W-1:0]     level_q, level_d;
    logic [FC_W-1:0]        fruit_q, fruit_d;
    logic                   lvl_pend_q, lvl_pend_d;
    logic                   pause_pend_q, pause_pend_d;
    logic                   clear_req_q, clear_req_d;
    logic                   step_req_q, step_req_d;
    logic [SW-1:0]          high_q, high_d;
    logic                   score_clr;
    logic [NUM_PLAYERS-1:0] inc;
    logic [NUM_PLAYERS*SW-1:0] scores;

    function automatic logic [31:0] period(input logic [LEVEL_W-1:0] lvl);
        logic [31:0] red;
        red = 32'(lvl) * 32'(DIV_STEP);
        if (red < 32'(TICK_DIV) && (32'(TICK_DIV) - red) > 32'(MIN_DIV))
            return 32'(TICK_DIV) - red;
        return 32'(MIN_DIV);
    endfunction

    // Digit-wise compare from the most significant digit down.
    function automatic logic bcd_gt(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic gt, done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = SCORE_DIGITS-1; i >= 0; i--) begin
            if (!done && a[i*DIGIT_W +: DIGIT_W] != b[i*DIGIT_W +: DIGIT_W]) begin
                gt   = a[i*DIGIT_W +: DIGIT_W] > b[i*DIGIT_W +: DIGIT_W];
                done = 1'b1;
            end
        end
        return gt;
    endfunction

    assign inc = (state_q == S_WAIT) ? (bus.fruit_eaten & alive_q) : '0;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
        bcd_counter #(.DIGITS(SCORE_DIGITS)) u_cnt (
            .clk_i (clk_i),
            .rst_i (reset_i),
            .clr_i (score_clr),
            .inc_i (inc[p]),
            .cnt_o (scores[p*SW +: SW])
        );
    end

    always_comb begin
        logic [2:0]      pc;
        logic [2:0]      live_n;
        logic [FC_W-1:0] fsum;
        logic            wrap;
        logic            new_game;
        logic [SW-1:0]   best;

        state_d      = state_q;
        cnt_d        = cnt_q;
        alive_d      = alive_q;
        level_d      = level_q;
        fruit_d      = fruit_q;
        lvl_pend_d   = lvl_pend_q;
        pause_pend_d = pause_pend_q;
        clear_req_d  = 1'b0;
        step_req_d   = 1'b0;
        high_d       = high_q;
        score_clr    = 1'b0;
        pc           = '0;
        live_n       = '0;
        fsum         = '0;
        wrap         = 1'b0;
        new_game     = 1'b0;
        best         = high_q;

        case (state_q)
            S_IDLE:  new_game = bus.start;
            S_CLEAR: begin
                if (bus.update_done) begin
                    state_d = S_RUN;
                    cnt_d   = period(level_q) - 32'd1;
                end
            end
            S_RUN: begin
                if (bus.pause_toggle) begin
                    state_d = S_PAUSE;
                end else if (cnt_q == 32'd0) begin
                    state_d    = S_WAIT;
                    step_req_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PAUSE: begin
                if (bus.start)             new_game = 1'b1;
                else if (bus.pause_toggle) state_d  = S_RUN;
            end
            S_WAIT: begin
                alive_d = alive_q & ~bus.collision;
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    pc     = pc + 3'(inc[p]);
                    live_n = live_n + 3'(alive_d[p]);
                end
                // Several simultaneous fruits may cross more than one wrap.
                fsum = fruit_q + FC_W'(pc);
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (fsum >= FC_W'(SPEEDUP_EVERY)) begin
                        fsum = fsum - FC_W'(SPEEDUP_EVERY);
                        wrap = 1'b1;
                    end
                end
                fruit_d    = fsum;
                lvl_pend_d = lvl_pend_q | wrap;
                if (bus.pause_toggle) pause_pend_d = 1'b1;
                if (bus.update_done) begin
                    lvl_pend_d   = 1'b0;
                    pause_pend_d = 1'b0;
                    if ((lvl_pend_q || wrap) && level_q != LEVEL_MAX)
                        level_d = level_q + 4'd1;
                    if (alive_d == '0 || (NUM_PLAYERS > 1 && live_n == 3'd1)) begin
                        state_d = S_OVER;
                    end else begin
                        cnt_d   = period(level_d) - 32'd1;
                        state_d = (pause_pend_q || bus.pause_toggle) ? S_PAUSE : S_RUN;
                    end
                end
            end
            S_OVER: begin
                for (int p = 0; p < NUM_PLAYERS; p++)
                    if (bcd_gt(scores[p*SW +: SW], best)) best = scores[p*SW +: SW];
                high_d   = best;
                new_game = bus.start;
            end
            default: state_d = S_IDLE;
        endcase

        if (new_game) begin
            state_d      = S_CLEAR;
            clear_req_d  = 1'b1;
            score_clr    = 1'b1;
            alive_d      = '1;
            level_d      = '0;
            fruit_d      = '0;
            lvl_pend_d   = 1'b0;
            pause_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alive_q      <= '0;
            level_q      <= '0;
            fruit_q      <= '0;
            lvl_pend_q   <= 1'b0;
            pause_pend_q <= 1'b0;
            clear_req_q  <= 1'b0;
            step_req_q   <= 1'b0;
            high_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alive_q      <= alive_d;
            level_q      <= level_d;
            fruit_q      <= fruit_d;
            lvl_pend_q   <= lvl_pend_d;
            pause_pend_q <= pause_pend_d;
            clear_req_q  <= clear_req_d;
            step_req_q   <= step_req_d;
            high_q       <= high_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.clear_req  = clear_req_q;
    assign bus.step_req   = step_req_q;
    assign bus.alive      = alive_q;
    assign bus.level      = level_q;
    assign bus.score      = scores;
    assign bus.high_score = high_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: reset, scoring/level speed-up, pause, game over,
// BCD carry/saturation and reset during an outstanding step.
module tb_game_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    game_ctrl_if #(.NUM_PLAYERS(2), .SCORE_DIGITS(5)) bus ();
    game_ctrl_if #(.NUM_PLAYERS(2), .SCORE_DIGITS(2)) b2 ();

    game_ctrl #(
        .NUM_PLAYERS(2), .SCORE_DIGITS(5), .TICK_DIV(8),
        .DIV_STEP(2), .MIN_DIV(4), .SPEEDUP_EVERY(2)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    game_ctrl #(
        .NUM_PLAYERS(2), .SCORE_DIGITS(2), .TICK_DIV(8),
        .DIV_STEP(2), .MIN_DIV(4), .SPEEDUP_EVERY(2)
    ) dut2 (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles from the current observation until step_req is seen.
    task automatic wait_step(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.step_req !== 1'b1 && n < 300);
        check(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        int seen;
        int n2;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.start = 0; bus.pause_toggle = 0; bus.fruit_eaten = 0;
        bus.collision = 0; bus.update_done = 0;
        b2.start = 0; b2.pause_toggle = 0; b2.fruit_eaten = 0;
        b2.collision = 0; b2.update_done = 0;
        tick(); tick();
        reset = 1'b0;

        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_clear_req", 64'(bus.clear_req), 64'd0);
        check("rst_step_req", 64'(bus.step_req), 64'd0);
        check("rst_alive", 64'(bus.alive), 64'd0);
        check("rst_level", 64'(bus.level), 64'd0);
        check("rst_score", 64'(bus.score), 64'd0);
        check("rst_high", 64'(bus.high_score), 64'd0);

        bus.update_done = 1; tick(); bus.update_done = 0;
        check("idle_ignores_done", 64'(bus.state), 64'd0);

        bus.start = 1; tick(); bus.start = 0;
        check("clear_state", 64'(bus.state), 64'd1);
        check("clear_req_pulse", 64'(bus.clear_req), 64'd1);
        check("clear_alive", 64'(bus.alive), 64'd3);
        tick();
        check("clear_req_single", 64'(bus.clear_req), 64'd0);

        bus.update_done = 1; tick(); bus.update_done = 0;
        check("run_state", 64'(bus.state), 64'd2);
        bus.start = 1; tick(); bus.start = 0;
        check("run_ignores_start", 64'(bus.state), 64'd2);
        wait_step("step_l0_first", 7);
        check("wait_state", 64'(bus.state), 64'd3);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.step_req) seen++;
        end
        check("no_extra_step", 64'(seen), 64'd0);

        bus.fruit_eaten = 2'b01; tick(); bus.fruit_eaten = 0;
        check("score_1", 64'(bus.score), 64'h00000_00001);
        bus.update_done = 1; tick(); bus.update_done = 0;
        check("level_after_1", 64'(bus.level), 64'd0);
        wait_step("step_l0", 8);

        bus.fruit_eaten = 2'b01; bus.update_done = 1; tick();
        bus.fruit_eaten = 0; bus.update_done = 0;
        check("score_2", 64'(bus.score), 64'h00000_00002);
        check("level_1", 64'(bus.level), 64'd1);
        wait_step("step_l1", 6);

        bus.fruit_eaten = 2'b11; bus.update_done = 1; tick();
        bus.fruit_eaten = 0; bus.update_done = 0;
        check("score_both", 64'(bus.score), 64'h00001_00003);
        check("level_2", 64'(bus.level), 64'd2);
        wait_step("step_l2", 4);

        bus.fruit_eaten = 2'b01; bus.update_done = 1; tick();
        bus.fruit_eaten = 0; bus.update_done = 0;
        wait_step("step_l2b", 4);
        bus.fruit_eaten = 2'b01; bus.update_done = 1; tick();
        bus.fruit_eaten = 0; bus.update_done = 0;
        check("level_3", 64'(bus.level), 64'd3);
        wait_step("step_l3_floor", 4);

        bus.pause_toggle = 1; tick(); bus.pause_toggle = 0;
        check("wait_holds_pause", 64'(bus.state), 64'd3);
        bus.update_done = 1; tick(); bus.update_done = 0;
        check("pend_pause", 64'(bus.state), 64'd4);
        bus.pause_toggle = 1; tick(); bus.pause_toggle = 0;
        check("resume_run", 64'(bus.state), 64'd2);
        wait_step("step_after_resume", 4);

        bus.update_done = 1; tick(); bus.update_done = 0;
        tick(); tick();
        bus.pause_toggle = 1; tick(); bus.pause_toggle = 0;
        check("run_pause", 64'(bus.state), 64'd4);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.step_req) seen++;
        end
        check("pause_no_step", 64'(seen), 64'd0);
        check("pause_stays", 64'(bus.state), 64'd4);
        bus.pause_toggle = 1; tick(); bus.pause_toggle = 0;
        wait_step("frozen_count", 2);

        bus.fruit_eaten = 2'b10; bus.collision = 2'b10; bus.update_done = 1; tick();
        bus.fruit_eaten = 0; bus.collision = 0; bus.update_done = 0;
        check("over_state", 64'(bus.state), 64'd5);
        check("over_alive", 64'(bus.alive), 64'd1);
        check("fruit_and_die", 64'(bus.score), 64'h00002_00005);
        tick();
        check("high_score", 64'(bus.high_score), 64'h00005);

        bus.start = 1; tick(); bus.start = 0;
        check("restart_state", 64'(bus.state), 64'd1);
        check("restart_score", 64'(bus.score), 64'd0);
        check("restart_high_kept", 64'(bus.high_score), 64'h00005);
        check("restart_level", 64'(bus.level), 64'd0);
        bus.update_done = 1; tick(); bus.update_done = 0;
        wait_step("restart_step", 8);

        bus.fruit_eaten = 2'b01;
        repeat (99) tick();
        check("bcd_99", 64'(bus.score), 64'h00000_00099);
        tick();
        bus.fruit_eaten = 0;
        check("bcd_carry_100", 64'(bus.score), 64'h00000_00100);
        bus.update_done = 1; tick(); bus.update_done = 0;
        check("one_level_per_exit", 64'(bus.level), 64'd1);
        wait_step("step_after_bulk", 6);

        bus.pause_toggle = 1; tick(); bus.pause_toggle = 0;
        reset = 1; tick(); reset = 0;
        check("midwait_state", 64'(bus.state), 64'd0);
        check("midwait_score", 64'(bus.score), 64'd0);
        check("midwait_high", 64'(bus.high_score), 64'd0);
        check("midwait_alive", 64'(bus.alive), 64'd0);
        bus.update_done = 1; tick(); bus.update_done = 0;
        check("late_done_ignored", 64'(bus.state), 64'd0);
        bus.start = 1; tick(); bus.start = 0;
        bus.update_done = 1; tick(); bus.update_done = 0;
        check("no_stale_pause", 64'(bus.state), 64'd2);
        wait_step("step_after_reset", 8);

        b2.start = 1; tick(); b2.start = 0;
        b2.update_done = 1; tick(); b2.update_done = 0;
        n2 = 0;
        do begin
            tick();
            n2++;
        end while (b2.step_req !== 1'b1 && n2 < 300);
        check("sat_step", 64'(n2), 64'd8);
        b2.fruit_eaten = 2'b01;
        repeat (99) tick();
        check("sat_reach_99", 64'(b2.score), 64'h00_99);
        repeat (3) tick();
        b2.fruit_eaten = 0;
        check("sat_hold_99", 64'(b2.score), 64'h00_99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
